tens_digit_ctrl: RTL

- Tens-digit counter and run controller for the game countdown timer.
- Sits on the far side of the ones-digit borrow interface:
  - consumes the ones digit's one-cycle borrow pulse;
  - returns the do-not-borrow flag;
  - gates the 1 s tick feeding the ones digit.
- Owns run/pause/expiry sequencing and raises the game time-out.

---
 rtl/tens_digit_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tens_digit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tens_digit_ctrl
// Brief    : Tens-digit counter and run/pause/expiry controller for the game
//            countdown timer. Sits on the far side of the ones-digit borrow
//            interface: it consumes the ones digit's borrow pulse, returns
//            the do-not-borrow flag and gates the 1 s tick that feeds the
//            ones digit.
// Ports    : clk, rst (sync, active-low)
//            onesec_in        - 1 s strobe from prescaler
//            borrow_in        - borrow pulse from ones digit
//            ones_in[3:0]     - current ones digit (BCD)
//            toggle_switch    - tens preset, clamped to MAX_TENS
//            reconfig         - level, load preset and hold in IDLE
//            start / pause    - one-cycle run control requests
//            tick_out         - gated 1 s strobe to ones digit
//            tens_out[3:0]    - tens digit (BCD)
//            donot_borrow_out - ones digit must stop at 0
//            time_out         - timer expired (level)
//            underflow_err    - sticky, borrow seen while tens digit was 0
//            warn             - low-time warning
// Options  : TENS_WARN_EN - enables the low-time warning comparator; when
//            undefined, warn is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tens_digit_ctrl #(
    parameter int unsigned MAX_TENS  = 9,
    parameter int unsigned WARN_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       onesec_in,
    input  logic       borrow_in,
    input  logic [3:0] ones_in,
    input  logic [3:0] toggle_switch,
    input  logic       reconfig,
    input  logic       start,
    input  logic       pause,
    output logic       tick_out,
    output logic [3:0] tens_out,
    output logic       donot_borrow_out,
    output logic       time_out,
    output logic       underflow_err,
    output logic       warn
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] C_MAX_TENS = 4'(MAX_TENS);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic       tick_q, tick_d;
    logic       dnb_q, dnb_d;
    logic       to_q, to_d;
    logic       uf_q, uf_d;
    logic       warn_q, warn_d;

    logic [3:0] preset;
    logic       at_zero;

    assign preset  = (toggle_switch > C_MAX_TENS) ? C_MAX_TENS : toggle_switch;
    assign at_zero = (tens_q == 4'd0) && (ones_in == 4'd0);

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        tick_d  = 1'b0;
        uf_d    = uf_q;
        warn_d  = 1'b0;

        if (reconfig) begin
            state_d = IDLE;
            tens_d  = preset;
            uf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Reaching 00 wins over a same-cycle pause, and no
                    // further tick is forwarded once the count is exhausted.
                    if (at_zero) begin
                        state_d = EXPIRED;
                    end else begin
                        tick_d = onesec_in;
                        if (pause) begin
                            state_d = PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = EXPIRED;
                end
            endcase

            // A borrow can still land one cycle into PAUSE because the tick
            // that caused it was issued while running, so PAUSE accepts it.
            if (borrow_in && ((state_q == RUN) || (state_q == PAUSE))) begin
                if (tens_q != 4'd0) begin
                    tens_d = tens_q - 4'd1;
                end else begin
                    uf_d = 1'b1;
                end
            end

`ifdef TENS_WARN_EN
            warn_d = ((state_q == RUN) || (state_q == PAUSE)) &&
                     (tens_q == 4'd0) && (ones_in <= 4'(WARN_SECS));
`endif
        end

        to_d  = (state_d == EXPIRED);
        // Looking at next-state values lets the flag rise in the same cycle
        // the tens digit reaches 0 rather than one cycle late.
        dnb_d = (tens_d == 4'd0) || (state_d != RUN);
    end

`ifndef TENS_WARN_EN
    logic [3:0] unused_warn_secs;
    assign unused_warn_secs = 4'(WARN_SECS);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tens_q  <= 4'd0;
            tick_q  <= 1'b0;
            dnb_q   <= 1'b1;
            to_q    <= 1'b0;
            uf_q    <= 1'b0;
            warn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            tick_q  <= tick_d;
            dnb_q   <= dnb_d;
            to_q    <= to_d;
            uf_q    <= uf_d;
            warn_q  <= warn_d;
        end
    end

    assign tick_out         = tick_q;
    assign tens_out         = tens_q;
    assign donot_borrow_out = dnb_q;
    assign time_out         = to_q;
    assign underflow_err    = uf_q;
    assign warn             = warn_q;

endmodule
`default_nettype wire
